// File: rtl/conf_store.sv
// conf_store: five 6-digit BCD user options (DIT, DAH, WORD, TOL, PPU) with
// combinational indexed read, saturating digit-edit writes, and a serial
// BCD->binary converter (one digit per ce cycle) feeding the timing logic.
// Optional build macro: CONF_MIN_ONE_EN -- clamp converted values to >= 1.
module conf_store #(
   parameter int                  DIGITS   = 6,
   parameter int                  BIN_W    = 20,
   parameter logic [DIGITS*4-1:0] DEF_DIT  = 24'h000100,
   parameter logic [DIGITS*4-1:0] DEF_DAH  = 24'h000300,
   parameter logic [DIGITS*4-1:0] DEF_WORD = 24'h000700,
   parameter logic [DIGITS*4-1:0] DEF_TOL  = 24'h000050,
   parameter logic [DIGITS*4-1:0] DEF_PPU  = 24'h000001
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic [2:0]            conf_selected_index,
   output logic [DIGITS*4-1:0]   conf_selected_value,
   input  logic [DIGITS*4-1:0]   conf_selected_new_value,
   input  logic                  conf_selected_set,
   output logic [BIN_W-1:0]      dit_units,
   output logic [BIN_W-1:0]      dah_units,
   output logic [BIN_W-1:0]      word_units,
   output logic [BIN_W-1:0]      tol_units,
   output logic [BIN_W-1:0]      ppu_units,
   output logic                  busy
);

   localparam int NOPT = 5;
   localparam int W    = DIGITS * 4;
   localparam int PW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // Same MSD-first x10 accumulation as the runtime converter, used to
   // derive the reset values of the binary outputs.
   function automatic logic [BIN_W-1:0] bcd2bin(input logic [W-1:0] v);
      logic [BIN_W+3:0] acc;
      acc = '0;
      for (int d = DIGITS - 1; d >= 0; d--)
         acc = (BIN_W+4)'(acc[BIN_W-1:0] * 10) + (BIN_W+4)'(v[d*4 +: 4]);
      return acc[BIN_W-1:0];
   endfunction

   // Clamp every nibble above 9 down to 9.
   function automatic logic [W-1:0] sat_bcd(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int d = 0; d < DIGITS; d++)
         if (v[d*4 +: 4] > 4'd9) r[d*4 +: 4] = 4'd9;
      return r;
   endfunction

   localparam logic [W-1:0]     DEF_BCD [NOPT] = '{DEF_DIT, DEF_DAH, DEF_WORD, DEF_TOL, DEF_PPU};
   localparam logic [BIN_W-1:0] DEF_BIN [NOPT] = '{bcd2bin(DEF_DIT), bcd2bin(DEF_DAH),
                                                   bcd2bin(DEF_WORD), bcd2bin(DEF_TOL),
                                                   bcd2bin(DEF_PPU)};

   // The load step is taken on the edge that leaves IDLE, so a conversion
   // occupies one load edge, DIGITS accumulate edges and one commit edge.
   typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

   state_t            r_state;
   logic [W-1:0]      r_bcd [NOPT];
   logic [BIN_W-1:0]  r_bin [NOPT];
   logic [NOPT-1:0]   r_pend;
   logic [2:0]        r_cur;
   logic [W-1:0]      r_snap;
   logic [BIN_W-1:0]  r_acc;
   logic [PW-1:0]     r_ptr;

   logic              w_wr;
   logic [NOPT-1:0]   w_set_vec;
   logic [NOPT-1:0]   w_clr_vec;
   logic [2:0]        w_lo;
   logic [W-1:0]      w_lo_bcd;
   logic [3:0]        w_digit;
   logic [BIN_W+3:0]  w_acc_ext;
   logic [BIN_W-1:0]  w_commit;
   logic              w_load;

   assign w_wr      = ce & conf_selected_set & (conf_selected_index < 3'(NOPT));
   assign w_load    = (r_state == S_IDLE) && (r_pend != '0);
   assign w_digit   = r_snap[{r_ptr, 2'b00} +: 4];
   assign w_acc_ext = ({4'b0000, r_acc} * (BIN_W+4)'(10)) + {{BIN_W{1'b0}}, w_digit};

`ifdef CONF_MIN_ONE_EN
   assign w_commit  = (r_acc == '0) ? BIN_W'(1) : r_acc;
`else
   assign w_commit  = r_acc;
`endif

   // Read mux, write one-hot, lowest pending option and its stored value.
   always_comb begin
      conf_selected_value = '0;
      w_set_vec           = '0;
      w_clr_vec           = '0;
      w_lo                = '0;
      w_lo_bcd            = '0;
      for (int i = 0; i < NOPT; i++) begin
         if (conf_selected_index == 3'(i)) conf_selected_value = r_bcd[i];
         w_set_vec[i] = w_wr && (conf_selected_index == 3'(i));
      end
      for (int i = NOPT - 1; i >= 0; i--)
         if (r_pend[i]) w_lo = 3'(i);
      for (int i = 0; i < NOPT; i++) begin
         if (w_lo == 3'(i)) w_lo_bcd = r_bcd[i];
         w_clr_vec[i] = w_load && (w_lo == 3'(i));
      end
   end

   // BCD option store: saturating writes from the menu.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NOPT; i++) r_bcd[i] <= DEF_BCD[i];
      end else if (ce) begin
         for (int i = 0; i < NOPT; i++)
            if (w_set_vec[i]) r_bcd[i] <= sat_bcd(conf_selected_new_value);
      end
   end

   // Pending tracking and serial conversion; a new set beats the load's clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pend  <= '0;
         r_cur   <= '0;
         r_snap  <= '0;
         r_acc   <= '0;
         r_ptr   <= '0;
         for (int i = 0; i < NOPT; i++) r_bin[i] <= DEF_BIN[i];
      end else if (ce) begin
         r_pend <= (r_pend & ~w_clr_vec) | w_set_vec;
         case (r_state)
            S_IDLE: begin
               if (w_load) begin
                  r_cur   <= w_lo;
                  r_snap  <= w_lo_bcd;
                  r_acc   <= '0;
                  r_ptr   <= PW'(DIGITS - 1);
                  r_state <= S_CONV;
               end
            end
            S_CONV: begin
               r_acc <= w_acc_ext[BIN_W-1:0];
               if (r_ptr == '0) r_state <= S_COMMIT;
               else             r_ptr   <= r_ptr - 1'b1;
            end
            S_COMMIT: begin
               for (int i = 0; i < NOPT; i++)
                  if (r_cur == 3'(i)) r_bin[i] <= w_commit;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dit_units  = r_bin[0];
   assign dah_units  = r_bin[1];
   assign word_units = r_bin[2];
   assign tol_units  = r_bin[3];
   assign ppu_units  = r_bin[4];
   assign busy       = (r_state != S_IDLE) | (|r_pend);

endmodule
